// File: rtl/sprite_palette_engine_if.sv
// sprite_palette_engine_if: pixel lookup, palette write, fade control and colour output bundle.
//   master: drives pix_*, wr_*, fade_start/fade_dir, frame_tick; observes outputs.
//   slave : the palette engine side.
interface sprite_palette_engine_if #(
    parameter int INDEX_W   = 4,
    parameter int NUM_BANKS = 4,
    parameter int CH_W      = 4
);
    localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    logic                  pix_valid;
    logic [INDEX_W-1:0]    pix_index;
    logic [BW-1:0]         pix_bank;
    logic                  wr_en;
    logic [BW-1:0]         wr_bank;
    logic [INDEX_W-1:0]    wr_index;
    logic [3*CH_W-1:0]     wr_rgb;
    logic                  fade_start;
    logic                  fade_dir;
    logic                  frame_tick;
    logic                  out_valid;
    logic [CH_W-1:0]       red;
    logic [CH_W-1:0]       green;
    logic [CH_W-1:0]       blue;
    logic                  transparent;
    logic                  fade_busy;
    logic [CH_W:0]         fade_level;
    modport master (
        output pix_valid, pix_index, pix_bank, wr_en, wr_bank, wr_index, wr_rgb,
               fade_start, fade_dir, frame_tick,
        input  out_valid, red, green, blue, transparent, fade_busy, fade_level
    );
    modport slave (
        input  pix_valid, pix_index, pix_bank, wr_en, wr_bank, wr_index, wr_rgb,
               fade_start, fade_dir, frame_tick,
        output out_valid, red, green, blue, transparent, fade_busy, fade_level
    );
endinterface

// File: rtl/sprite_palette_engine.sv
// sprite_palette_engine: banked writable palette lookup with transparent key and frame-stepped fade.
//   clk, rst : clock, asynchronous active-high reset.
//   bus      : pixel lookup request, palette write port, fade commands in; scaled colour,
//              transparent flag, fade status out. Output latency is 2 cycles.
module sprite_palette_engine #(
    parameter int INDEX_W      = 4,
    parameter int NUM_BANKS    = 4,
    parameter int CH_W         = 4,
    parameter int TRANSP_INDEX = 0
) (
    input logic clk,
    input logic rst,
    sprite_palette_engine_if.slave bus
);
    localparam int ENTRIES = 2 ** INDEX_W;
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FADE_OUT = 2'd1;
    localparam logic [1:0] FADE_IN  = 2'd2;
    localparam logic [CH_W:0] FULL  = {1'b1, {CH_W{1'b0}}};

    logic [3*CH_W-1:0] pal_q [NUM_BANKS][ENTRIES];
    logic              s1_valid_q, s1_transp_q;
    logic [3*CH_W-1:0] s1_rgb_q;
    logic              out_valid_q, transp_q;
    logic [CH_W-1:0]   red_q, green_q, blue_q;
    logic [1:0]        st_q, st_d;
    logic [CH_W:0]     lvl_q, lvl_d;

    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [CH_W:0] l);
        logic [2*CH_W:0] p;
        p = {{(CH_W+1){1'b0}}, c} * {{CH_W{1'b0}}, l};
        return CH_W'(p >> CH_W);
    endfunction

    // Stage 1 reads the pre-edge array contents, so a same-cycle write to the
    // looked-up entry naturally yields the old colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int i = 0; i < ENTRIES; i++)
                    pal_q[b][i] <= '1;
        end else if (bus.wr_en) begin
            pal_q[bus.wr_bank][bus.wr_index] <= bus.wr_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_transp_q <= 1'b0;
            s1_rgb_q    <= '0;
            out_valid_q <= 1'b0;
            transp_q    <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            s1_valid_q  <= bus.pix_valid;
            s1_transp_q <= bus.pix_index == INDEX_W'(TRANSP_INDEX);
            s1_rgb_q    <= pal_q[bus.pix_bank][bus.pix_index];
            out_valid_q <= s1_valid_q;
            transp_q    <= s1_transp_q;
            red_q       <= scale(s1_rgb_q[3*CH_W-1 -: CH_W], lvl_q);
            green_q     <= scale(s1_rgb_q[2*CH_W-1 -: CH_W], lvl_q);
            blue_q      <= scale(s1_rgb_q[CH_W-1:0], lvl_q);
        end
    end

    // fade_start takes priority over a coincident tick; reaching (or already
    // sitting at) the target level on a tick returns to IDLE.
    always_comb begin
        st_d  = st_q;
        lvl_d = lvl_q;
        if (bus.fade_start) begin
            st_d = bus.fade_dir ? FADE_IN : FADE_OUT;
        end else if (bus.frame_tick && st_q == FADE_OUT) begin
            lvl_d = (lvl_q == '0) ? lvl_q : lvl_q - 1'b1;
            st_d  = (lvl_d == '0) ? IDLE : FADE_OUT;
        end else if (bus.frame_tick && st_q == FADE_IN) begin
            lvl_d = (lvl_q == FULL) ? lvl_q : lvl_q + 1'b1;
            st_d  = (lvl_d == FULL) ? IDLE : FADE_IN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= IDLE;
            lvl_q <= FULL;
        end else begin
            st_q  <= st_d;
            lvl_q <= lvl_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.transparent = transp_q;
    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.fade_busy   = st_q != IDLE;
    assign bus.fade_level  = lvl_q;
endmodule

// File: tb/tb_sprite_palette_engine.sv
// tb_sprite_palette_engine: directed checks of lookup, write collision, transparency, fades and reset.
module tb_sprite_palette_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;

    sprite_palette_engine_if bus ();

    sprite_palette_engine dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pix_valid  = 1'b0;
        bus.pix_index  = '0;
        bus.pix_bank   = '0;
        bus.wr_en      = 1'b0;
        bus.wr_bank    = '0;
        bus.wr_index   = '0;
        bus.wr_rgb     = '0;
        bus.fade_start = 1'b0;
        bus.fade_dir   = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    task automatic write(input logic [1:0] b, input logic [3:0] i, input logic [11:0] rgb);
        bus.wr_en = 1'b1; bus.wr_bank = b; bus.wr_index = i; bus.wr_rgb = rgb;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic lookup(input logic [1:0] b, input logic [3:0] i);
        bus.pix_valid = 1'b1; bus.pix_bank = b; bus.pix_index = i;
        step();
        bus.pix_valid = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic fade(input logic dir);
        bus.fade_start = 1'b1; bus.fade_dir = dir;
        step();
        bus.fade_start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'h000) begin fails++; $display("FAIL reset_rgb got %h want 000", {bus.red, bus.green, bus.blue}); end
        checks++; if (bus.transparent !== 1'b0) begin fails++; $display("FAIL reset_transp got %0b want 0", bus.transparent); end
        checks++; if (bus.fade_level !== 5'd16 || bus.fade_busy !== 1'b0) begin fails++; $display("FAIL reset_fade got %0d/%0b want 16/0", bus.fade_level, bus.fade_busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lookup();
        bus.pix_valid = 1'b1; bus.pix_bank = 2'd0; bus.pix_index = 4'd3;
        step();
        bus.pix_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL latency_early got %0b want 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL latency_valid got %0b want 1", bus.out_valid); end
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'hFFF || bus.transparent !== 1'b0) begin fails++; $display("FAIL lookup_white got %h/%0b want fff/0", {bus.red, bus.green, bus.blue}, bus.transparent); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL valid_single got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_write_collision();
        write(2'd2, 4'd5, 12'hF00);
        lookup(2'd2, 4'd5);
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'hF00) begin fails++; $display("FAIL write_read got %h want f00", {bus.red, bus.green, bus.blue}); end
        lookup(2'd0, 4'd5);
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'hFFF) begin fails++; $display("FAIL other_bank got %h want fff", {bus.red, bus.green, bus.blue}); end
        bus.wr_en = 1'b1; bus.wr_bank = 2'd2; bus.wr_index = 4'd5; bus.wr_rgb = 12'h00F;
        bus.pix_valid = 1'b1; bus.pix_bank = 2'd2; bus.pix_index = 4'd5;
        step();
        bus.wr_en = 1'b0; bus.pix_valid = 1'b0;
        step();
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'hF00) begin fails++; $display("FAIL collision_old got %h want f00", {bus.red, bus.green, bus.blue}); end
        lookup(2'd2, 4'd5);
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'h00F) begin fails++; $display("FAIL collision_new got %h want 00f", {bus.red, bus.green, bus.blue}); end
    endtask

    task automatic test_transparent();
        lookup(2'd1, 4'd0);
        checks++; if (bus.transparent !== 1'b1 || {bus.red, bus.green, bus.blue} !== 12'hFFF) begin fails++; $display("FAIL transp_idx0 got %0b/%h want 1/fff", bus.transparent, {bus.red, bus.green, bus.blue}); end
        lookup(2'd1, 4'd1);
        checks++; if (bus.transparent !== 1'b0 || bus.out_valid !== 1'b1) begin fails++; $display("FAIL transp_idx1 got %0b/%0b want 0/1", bus.transparent, bus.out_valid); end
    endtask

    task automatic test_fade_out();
        write(2'd0, 4'd7, 12'hF82);
        fade(1'b0);
        checks++; if (bus.fade_busy !== 1'b1 || bus.fade_level !== 5'd16) begin fails++; $display("FAIL fade_start got %0b/%0d want 1/16", bus.fade_busy, bus.fade_level); end
        ticks(8);
        checks++; if (bus.fade_level !== 5'd8) begin fails++; $display("FAIL fade_half got %0d want 8", bus.fade_level); end
        lookup(2'd0, 4'd7);
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'h741) begin fails++; $display("FAIL scale_8 got %h want 741", {bus.red, bus.green, bus.blue}); end
        ticks(7);
        checks++; if (bus.fade_busy !== 1'b1 || bus.fade_level !== 5'd1) begin fails++; $display("FAIL fade_15 got %0b/%0d want 1/1", bus.fade_busy, bus.fade_level); end
        ticks(1);
        checks++; if (bus.fade_busy !== 1'b0 || bus.fade_level !== 5'd0) begin fails++; $display("FAIL fade_16 got %0b/%0d want 0/0", bus.fade_busy, bus.fade_level); end
        lookup(2'd0, 4'd7);
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'h000) begin fails++; $display("FAIL scale_0 got %h want 000", {bus.red, bus.green, bus.blue}); end
        fade(1'b0);
        checks++; if (bus.fade_busy !== 1'b1) begin fails++; $display("FAIL at_target_enter got %0b want 1", bus.fade_busy); end
        ticks(1);
        checks++; if (bus.fade_busy !== 1'b0 || bus.fade_level !== 5'd0) begin fails++; $display("FAIL at_target_exit got %0b/%0d want 0/0", bus.fade_busy, bus.fade_level); end
    endtask

    task automatic test_fade_retarget();
        fade(1'b1);
        ticks(16);
        checks++; if (bus.fade_busy !== 1'b0 || bus.fade_level !== 5'd16) begin fails++; $display("FAIL fade_in_full got %0b/%0d want 0/16", bus.fade_busy, bus.fade_level); end
        fade(1'b0);
        ticks(6);
        checks++; if (bus.fade_level !== 5'd10) begin fails++; $display("FAIL fade_to_10 got %0d want 10", bus.fade_level); end
        bus.fade_start = 1'b1; bus.fade_dir = 1'b1; bus.frame_tick = 1'b1;
        step();
        bus.fade_start = 1'b0; bus.frame_tick = 1'b0;
        checks++; if (bus.fade_level !== 5'd10 || bus.fade_busy !== 1'b1) begin fails++; $display("FAIL start_wins got %0d/%0b want 10/1", bus.fade_level, bus.fade_busy); end
        ticks(5);
        checks++; if (bus.fade_level !== 5'd15 || bus.fade_busy !== 1'b1) begin fails++; $display("FAIL climb_15 got %0d/%0b want 15/1", bus.fade_level, bus.fade_busy); end
        ticks(1);
        checks++; if (bus.fade_level !== 5'd16 || bus.fade_busy !== 1'b0) begin fails++; $display("FAIL climb_16 got %0d/%0b want 16/0", bus.fade_level, bus.fade_busy); end
    endtask

    task automatic test_back_to_back();
        bus.pix_valid = 1'b1; bus.pix_bank = 2'd2; bus.pix_index = 4'd5;
        step();
        bus.pix_bank = 2'd1; bus.pix_index = 4'd0;
        step();
        checks++; if (bus.out_valid !== 1'b1 || {bus.red, bus.green, bus.blue} !== 12'h00F) begin fails++; $display("FAIL b2b_first got %0b/%h want 1/00f", bus.out_valid, {bus.red, bus.green, bus.blue}); end
        bus.pix_bank = 2'd0; bus.pix_index = 4'd7;
        step();
        checks++; if (bus.transparent !== 1'b1 || {bus.red, bus.green, bus.blue} !== 12'hFFF) begin fails++; $display("FAIL b2b_second got %0b/%h want 1/fff", bus.transparent, {bus.red, bus.green, bus.blue}); end
        bus.pix_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.transparent !== 1'b0 || {bus.red, bus.green, bus.blue} !== 12'hF82) begin fails++; $display("FAIL b2b_third got %0b/%0b/%h want 1/0/f82", bus.out_valid, bus.transparent, {bus.red, bus.green, bus.blue}); end
    endtask

    task automatic test_reset_mid_fade();
        fade(1'b0);
        ticks(3);
        bus.pix_valid = 1'b1; bus.pix_bank = 2'd2; bus.pix_index = 4'd5;
        step();
        bus.pix_index = 4'd6;
        step();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.fade_level !== 5'd16 || bus.fade_busy !== 1'b0) begin fails++; $display("FAIL async_reset got %0b/%0d/%0b want 0/16/0", bus.out_valid, bus.fade_level, bus.fade_busy); end
        idle_inputs();
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flushed got %0b want 0", bus.out_valid); end
        lookup(2'd2, 4'd5);
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'hFFF) begin fails++; $display("FAIL wipe_b2 got %h want fff", {bus.red, bus.green, bus.blue}); end
        lookup(2'd0, 4'd7);
        checks++; if ({bus.red, bus.green, bus.blue} !== 12'hFFF) begin fails++; $display("FAIL wipe_b0 got %h want fff", {bus.red, bus.green, bus.blue}); end
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_write_collision();
        test_transparent();
        test_fade_out();
        test_fade_retarget();
        test_back_to_back();
        test_reset_mid_fade();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sprite_palette_engine.md
Name: sprite_palette_engine

Overview:
Multi-bank, runtime-writable palette lookup for sprite rendering. Each pixel index maps to an RGB colour, with a per-design transparent colour key and a frame-stepped global fade (fade to black, fade in) for level transitions and death effects. It sits between the sprite ROM index outputs and the VGA colour mux, and replaces the fixed per-sprite palette modules. Output is registered, with a fixed 2-cycle latency.

Parameters:
INDEX_W, 4, width of the pixel colour index; each bank holds 2**INDEX_W entries.
NUM_BANKS, 4, number of palettes (e.g. boy, girl, level, UI); must be a power of 2, at least 1.
CH_W, 4, bits per colour channel.
TRANSP_INDEX, 0, index value treated as transparent in every bank.

Ports:
Clk  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
pix_valid  in  1  pixel lookup request this cycle.
pix_index  in  INDEX_W  colour index from the sprite ROM.
pix_bank  in  clog2(NUM_BANKS) (min 1)  palette bank for this pixel.
wr_en  in  1  palette entry write strobe.
wr_bank  in  clog2(NUM_BANKS) (min 1)  bank to write.
wr_index  in  INDEX_W  entry to write.
wr_rgb  in  3*CH_W  colour to write, packed {r,g,b}.
fade_start  in  1  single-cycle command to start a fade.
fade_dir  in  1  0 = fade to black, 1 = fade to full brightness; sampled with fade_start.
frame_tick  in  1  single-cycle pulse once per frame (vsync edge).
out_valid  out  1  red/green/blue/transparent valid.
red, green, blue  out  CH_W each  scaled colour.
transparent  out  1  the pixel index equalled TRANSP_INDEX.
fade_busy  out  1  a fade is in progress.
fade_level  out  CH_W+1  current brightness, 0..2**CH_W.

Behaviour:
- Storage: NUM_BANKS x 2**INDEX_W entries, each 3*CH_W bits, held in registers.
  - On Reset every entry is all-ones (white).
  - Writes take effect at the Clk edge where wr_en=1.
  - Out-of-range bank values cannot occur, because NUM_BANKS is a power of 2.
- Stage 1 (edge after the request): latch the entry at [pix_bank][pix_index], the transparent flag (pix_index==TRANSP_INDEX) and valid=pix_valid.
- Read/write collision: a lookup and a write to the same bank/index in the same cycle returns the OLD entry. The new value is visible from the next cycle.
- Stage 2: each channel out = (c * fade_level) >> CH_W, using a product width of 2*CH_W+1.
  - fade_level = 2**CH_W gives the channel unchanged; 0 gives 0.
  - Stage 2 uses fade_level as it is registered at the stage-2 edge.
  - transparent and valid pass through unchanged.
  - Colour is scaled even when transparent=1; the downstream mux ignores it.
- Latency: out_valid is high exactly 2 cycles after pix_valid. The pipeline is fully pipelined: one lookup per cycle, no stalls.
- Fade FSM states: IDLE, FADE_OUT, FADE_IN.
  - IDLE + fade_start: go to FADE_OUT if fade_dir=0, else FADE_IN. Level does not change on this edge.
  - FADE_OUT: each frame_tick decrements fade_level by 1. When the decrement reaches 0, return to IDLE.
  - FADE_IN: each frame_tick increments fade_level by 1. When the increment reaches 2**CH_W, return to IDLE.
  - fade_start while fading: re-target to the new direction from the current level. No jump.
  - fade_start and frame_tick in the same cycle: fade_start wins and there is no step that cycle.
  - Already at the target (e.g. fade out at level 0): enter the state, then return to IDLE on the next frame_tick with the level unchanged.
  - fade_busy = (state != IDLE).
- Reset values: fade_level = 2**CH_W; state IDLE; fade_busy=0; out_valid=0; red/green/blue=0; transparent=0; both pipeline stages cleared.
- Reset asserted mid-fade or mid-pipeline: all of the above take effect immediately. Palette contents return to white.

Test Plan:
- Reset, then pix_valid=1, index 3, bank 0 -> out_valid=1 two cycles later, rgb = F,F,F, transparent=0.
- Write bank 2 idx 5 = {F,0,0}, then read bank 2 idx 5 -> F,0,0. A same-cycle write+read of idx 5 with new {0,0,F} -> old F,0,0, and the next read gives 0,0,F.
- Read idx 0 in any bank -> transparent=1 with rgb still reported. Read idx 1 -> transparent=0.
- fade_start dir=0, then 16 frame_ticks -> fade_level 16->0, fade_busy falls on the 16th tick. Entry {F,8,2} at levels 8 and 0 -> {7,4,1} and {0,0,0}.
- Fade out to level 10, then fade_start dir=1 -> level climbs 10->16 over 6 ticks. fade_start coincident with a tick -> no step that cycle.
- Assert Reset mid-fade with back-to-back lookups in flight -> out_valid=0, fade_level=16, fade_busy=0, written entries read back F,F,F.
